// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sequencer
// Purpose  : Generates the 2-bit mode select and the blanking control for the
//            four-input LED mode chooser. Modes step on debounced next/prev
//            buttons or on a dwell timer. A mask lets modes be skipped. Each
//            mode change is followed by a short blank interval that also acts
//            as a restart strobe for the pattern generators.
// Ports    : clk            - system clock
//            reset          - synchronous, active-high reset
//            i_btn_next     - raw async button, rising edge -> next mode
//            i_btn_prev     - raw async button, rising edge -> previous mode
//            i_auto_en      - 1 enables dwell-timer auto-advance
//            i_mode_mask    - bit i = 1 means mode i is selectable
//            o_mode_sel     - registered mode select
//            o_blank        - registered, 1 forces chooser output to zero
//            o_mode_changed - one-cycle pulse on the first cycle of a new mode
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int BLANK_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_next,
  input  logic       i_btn_prev,
  input  logic       i_auto_en,
  input  logic [3:0] i_mode_mask,
  output logic [1:0] o_mode_sel,
  output logic       o_blank,
  output logic       o_mode_changed
);

  localparam int c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_DWELL_W = (AUTO_PERIOD > 1)     ? $clog2(AUTO_PERIOD)     : 1;
  localparam int c_BLANK_W = (BLANK_CYCLES > 1)    ? $clog2(BLANK_CYCLES)    : 1;

  localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(AUTO_PERIOD - 1);
  localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_OFF   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = next, bit 1 = prev
  // --------------------------------------------------------------------------
  logic [1:0]        w_raw;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_db;
  logic [1:0]        r_evt;
  logic [c_DB_W-1:0] r_db_cnt [2];

  assign w_raw = {i_btn_prev, i_btn_next};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_db        <= '0;
      r_evt       <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 2; b++) begin
        r_evt[b] <= 1'b0;
        if (r_sync2[b] != r_db[b]) begin
          if (r_db_cnt[b] == c_DB_LAST) begin
            r_db[b]     <= r_sync2[b];
            r_db_cnt[b] <= '0;
            // Only an accepted low-to-high transition is an event.
            r_evt[b]    <= r_sync2[b];
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Mode search helpers
  // --------------------------------------------------------------------------
  // Returns {found, index}. Scans offsets 3..1 so the nearest hit wins.
  function automatic logic [2:0] f_search(input logic [1:0] m,
                                          input logic [3:0] mask,
                                          input logic       up);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, m};
    for (int k = 3; k >= 1; k--) begin
      idx = up ? (m + 2'(k)) : (m - 2'(k));
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [1:0] f_lowest(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_mode;
  logic [1:0]            w_mode_nxt;
  logic                  r_blank;
  logic                  r_changed;
  logic                  w_changed_nxt;
  logic [c_BLANK_W-1:0]  r_blank_cnt;
  logic [c_BLANK_W-1:0]  w_blank_cnt_nxt;
  logic [c_DWELL_W-1:0]  r_dwell;
  logic [c_DWELL_W-1:0]  w_dwell_nxt;
  logic [2:0]            w_next_res;
  logic [2:0]            w_prev_res;
  logic                  w_req;
  logic [2:0]            w_req_res;

  assign w_next_res = f_search(r_mode, i_mode_mask, 1'b1);
  assign w_prev_res = f_search(r_mode, i_mode_mask, 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BLANK;
      r_mode      <= 2'd0;
      r_blank     <= 1'b1;
      r_changed   <= 1'b0;
      r_blank_cnt <= '0;
      r_dwell     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_blank     <= (w_state_nxt != ST_RUN);
      r_changed   <= w_changed_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
      r_dwell     <= w_dwell_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_changed_nxt   = 1'b0;
    w_blank_cnt_nxt = '0;
    w_dwell_nxt     = '0;   // any path that does not count clears the dwell
    w_req           = 1'b0;
    w_req_res       = 3'd0;

    case (r_state)
      ST_BLANK: begin
        // Button events and the timer are dropped while blanking.
        if (r_blank_cnt == c_BLANK_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (i_mode_mask == 4'd0) begin
          w_state_nxt = ST_OFF;
          w_mode_nxt  = 2'd0;
        end else if (!i_mode_mask[r_mode]) begin
          w_req     = 1'b1;
          w_req_res = w_next_res;
        end else if (r_evt[0] && r_evt[1]) begin
          // Conflicting requests cancel each other.
        end else if (r_evt[0]) begin
          w_req     = 1'b1;
          w_req_res = w_next_res;
        end else if (r_evt[1]) begin
          w_req     = 1'b1;
          w_req_res = w_prev_res;
        end else if (i_auto_en) begin
          if (r_dwell == c_DWELL_LAST) begin
            w_req     = 1'b1;
            w_req_res = w_next_res;
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
      end

      ST_OFF: begin
        w_mode_nxt = 2'd0;
        if (i_mode_mask != 4'd0) begin
          w_mode_nxt    = f_lowest(i_mode_mask);
          w_changed_nxt = 1'b1;
          w_state_nxt   = ST_BLANK;
        end
      end

      default: begin
        w_state_nxt = ST_BLANK;
        w_mode_nxt  = 2'd0;
      end
    endcase

    // A request that lands on the current mode only restarts the dwell timer.
    if (w_req && w_req_res[2] && (w_req_res[1:0] != r_mode)) begin
      w_mode_nxt    = w_req_res[1:0];
      w_changed_nxt = 1'b1;
      w_state_nxt   = ST_BLANK;
    end
  end

  assign o_mode_sel     = r_mode;
  assign o_blank        = r_blank;
  assign o_mode_changed = r_changed;

endmodule
`default_nettype wire
